descrambler_mlane: RTL and testbench
====================================

Name: descrambler_mlane

Overview:
Parametrised multi-lane self-synchronous 64b/66b descrambler, polynomial x^58+x^39+1. It is the successor of the single-lane 64-bit descrambler in the low-latency PCS RX path, and sits between the RX gearbox/block-sync and the 66b decoder. It adds:
- LANES independent channels.
- DW-bit beats, so one 66b block can span several beats.
- Per-lane bypass.
- Sync-header error detection with a saturating error counter.
- Optional per-lane block-lock FSM.

Parameters:
LANES, 4, number of independent lanes.
DW, 64, data bits per lane per beat; legal values 16, 32, 64; 64/DW beats per 66b block.
ECW, 16, width of the header-error counter.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
en  in  LANES  per-lane beat valid.
sof  in  LANES  per-lane first beat of a block; head_i is qualified by en&sof.
data_i  in  LANES*DW  scrambled data; lane l occupies [l*DW +: DW]; bit 0 is the first received bit.
head_i  in  LANES*2  sync header per lane.
byp  in  LANES  per-lane bypass (quasi-static).
err_clr  in  1  synchronous clear of err_cnt.
data_o  out  LANES*DW  descrambled data.
head_o  out  LANES*2  registered header (valid on sof beats).
sof_o  out  LANES  registered sof.
vld  out  LANES  registered en.
hdr_err  out  LANES  1-cycle pulse: header 00 or 11 on a sof beat.
err_cnt  out  ECW  saturating total of header errors across all lanes.
lock  out  LANES  block lock per lane.

Behaviour:
- Reset values:
  - per-lane 58-bit state S = all ones;
  - data_o = 0, head_o = 0, sof_o = 0, vld = 0, hdr_err = 0, err_cnt = 0;
  - lock = 0 with LOCK_EN defined, otherwise all ones.
- Latency: 1 clk for every output, from en to vld.
- Per lane, when en[l]=1, bits i = 0..DW-1 are processed in order:
  - out[i] = d[i] ^ S[0] ^ S[19];
  - then S = {d[i], S[57:1]}.
  - S advances DW bits per beat. Data advance is independent of sof.
- byp[l]=1: data_o = data_i unchanged, but S still updates with the input bits, so descrambling is correct immediately after byp drops.
- en[l]=0:
  - S and data_o hold;
  - vld = 0, sof_o = 0, hdr_err = 0;
  - head_o holds.
- Header check, only on en&sof:
  - head_i of 2'b00 or 2'b11 → hdr_err[l] = 1 the following cycle.
  - head_o and sof_o are registered alongside data.
- err_cnt:
  - adds popcount(hdr_err events) in the cycle each event is detected;
  - saturates at 2^ECW-1, with no wrap;
  - err_clr has priority: when err_clr coincides with events, err_cnt becomes 0 and those events are dropped.
- Lanes are fully independent. Simultaneous en on all lanes is legal.
- en&sof with en=0 is ignored.
- Reset asserted mid-block returns S to all ones. The first post-reset 58 bits are therefore garbage by design.

Optional Feature:
Macro DESCR_LOCK_EN.
Defined: per-lane FSM with states UNLOCK, LOCKED, counting only en&sof beats.
- UNLOCK: good-header counter gc increments on each valid header.
  - An invalid header resets gc to 0.
  - gc reaching 64 → LOCKED.
- LOCKED: within each window of 64 headers, invalid headers are counted in bc.
  - bc reaching 16 → UNLOCK, with gc = 0 and bc = 0.
  - At the window end (64 headers), bc = 0.
- lock = (state == LOCKED), registered.
- Data path is unaffected by lock.
Undefined: no FSM; lock tied to all ones.

Test Plan:
- Reset, then DW=64, lane 0 en=1, data_i=0 for two beats → beat 1 data_o = 0x03FFFF8000000000, beat 2 = 0; vld rises 1 clk after en.
- Scramble random 66b blocks with a reference scrambler (seed arbitrary) on all 4 lanes; DW=16 and 32 builds → after 58 bits, data_o equals the plaintext every beat on every lane.
- byp[1]=1 for 10 beats, then 0 → data_o equals data_i during bypass; plaintext correct on the first beat after release.
- head_i=2'b11 on lanes 0 and 2 in the same sof beat → hdr_err = 4'b0101 for one cycle; err_cnt += 2. Force err_cnt to 0xFFFE, then 2 errors → 0xFFFF. Same-cycle err_clr → 0.
- DESCR_LOCK_EN: 64 good headers → lock=1 after the 64th; then 16 bad headers inside one 64-header window → lock=0; 15 bad per window → lock stays 1.
- rst_n asserted mid-stream → all outputs zero immediately (asynchronous); S back to all ones; lock=0.

Source files
------------

// File: rtl/descrambler_mlane.sv
// descrambler_mlane: per-lane self-synchronous x^58+x^39+1 descrambler with sync-header checking.
// Latency: 1 clk from en/data_i/head_i to every output; optional block-lock FSM when DESCR_LOCK_EN is defined.
// Backpressure: none, en is a pure per-lane beat valid and the block accepts a beat on every lane every cycle.
module descrambler_mlane #(
    parameter int LANES = 4,
    parameter int DW    = 64,
    parameter int ECW   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LANES-1:0]      en,
    input  logic [LANES-1:0]      sof,
    input  logic [LANES*DW-1:0]   data_i,
    input  logic [LANES*2-1:0]    head_i,
    input  logic [LANES-1:0]      byp,
    input  logic                  err_clr,
    output logic [LANES*DW-1:0]   data_o,
    output logic [LANES*2-1:0]    head_o,
    output logic [LANES-1:0]      sof_o,
    output logic [LANES-1:0]      vld,
    output logic [LANES-1:0]      hdr_err,
    output logic [ECW-1:0]        err_cnt,
    output logic [LANES-1:0]      lock
);
    localparam int PCW = $clog2(LANES + 1);

    logic [57:0]         s_q [LANES];
    logic [57:0]         s_d [LANES];
    logic [LANES*DW-1:0] data_q, data_d;
    logic [LANES*2-1:0]  head_q, head_d;
    logic [LANES-1:0]    sof_q, sof_d;
    logic [LANES-1:0]    vld_q, vld_d;
    logic [LANES-1:0]    hdr_err_q, hdr_err_d;
    logic [ECW-1:0]      err_cnt_q, err_cnt_d;
    logic [PCW-1:0]      err_pop;
    logic [ECW+PCW-1:0]  err_sum;

    // Walk each lane's beat bit by bit; the state always shifts in the received (scrambled) bit, bypass only picks the output.
    always_comb begin
        logic [57:0] st;
        logic        b;
        st     = '0;
        b      = 1'b0;
        data_d = data_q;
        for (int l = 0; l < LANES; l++) begin
            st = s_q[l];
            if (en[l]) begin
                for (int i = 0; i < DW; i++) begin
                    b                = data_i[l*DW + i];
                    data_d[l*DW + i] = byp[l] ? b : (b ^ st[0] ^ st[19]);
                    st               = {b, st[57:1]};
                end
            end
            s_d[l] = st;
        end
    end

    // Qualify sideband per lane; a header is only looked at on en&sof and is invalid when both bits are equal.
    always_comb begin
        head_d    = head_q;
        vld_d     = '0;
        sof_d     = '0;
        hdr_err_d = '0;
        for (int l = 0; l < LANES; l++) begin
            vld_d[l]     = en[l];
            sof_d[l]     = en[l] & sof[l];
            hdr_err_d[l] = en[l] & sof[l] & (head_i[2*l+1] == head_i[2*l]);
            if (en[l] & sof[l]) begin
                head_d[2*l +: 2] = head_i[2*l +: 2];
            end
        end
    end

    // Saturating sum of this cycle's header errors; a clear wins and discards same-cycle events.
    always_comb begin
        err_pop = '0;
        for (int l = 0; l < LANES; l++) begin
            err_pop = err_pop + PCW'(hdr_err_d[l]);
        end
        err_sum = {{PCW{1'b0}}, err_cnt_q} + {{ECW{1'b0}}, err_pop};
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (err_sum > {{PCW{1'b0}}, {ECW{1'b1}}}) begin
            err_cnt_d = '1;
        end else begin
            err_cnt_d = err_sum[ECW-1:0];
        end
    end

    // Datapath registers; the scrambler state restarts at all ones on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                s_q[l] <= '1;
            end
            data_q    <= '0;
            head_q    <= '0;
            sof_q     <= '0;
            vld_q     <= '0;
            hdr_err_q <= '0;
            err_cnt_q <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                s_q[l] <= s_d[l];
            end
            data_q    <= data_d;
            head_q    <= head_d;
            sof_q     <= sof_d;
            vld_q     <= vld_d;
            hdr_err_q <= hdr_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign data_o  = data_q;
    assign head_o  = head_q;
    assign sof_o   = sof_q;
    assign vld     = vld_q;
    assign hdr_err = hdr_err_q;
    assign err_cnt = err_cnt_q;

`ifdef DESCR_LOCK_EN
    typedef enum logic {UNLOCK = 1'b0, LOCKED = 1'b1} lock_st_e;

    lock_st_e   st_q [LANES];
    lock_st_e   st_d [LANES];
    logic [5:0] gc_q [LANES];
    logic [5:0] gc_d [LANES];
    logic [5:0] wc_q [LANES];
    logic [5:0] wc_d [LANES];
    logic [3:0] bc_q [LANES];
    logic [3:0] bc_d [LANES];

    // Lock state per lane: only en&sof beats move it; 64 consecutive good headers lock, 16 bad in a 64-header window unlock.
    always_comb begin
        logic hv;
        hv = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            st_d[l] = st_q[l];
            gc_d[l] = gc_q[l];
            wc_d[l] = wc_q[l];
            bc_d[l] = bc_q[l];
            hv      = head_i[2*l+1] ^ head_i[2*l];
            if (en[l] & sof[l]) begin
                case (st_q[l])
                    UNLOCK: begin
                        if (!hv) begin
                            gc_d[l] = '0;
                        end else if (gc_q[l] == 6'd63) begin
                            st_d[l] = LOCKED;
                            gc_d[l] = '0;
                            wc_d[l] = '0;
                            bc_d[l] = '0;
                        end else begin
                            gc_d[l] = gc_q[l] + 6'd1;
                        end
                    end
                    LOCKED: begin
                        if (!hv && bc_q[l] == 4'd15) begin
                            st_d[l] = UNLOCK;
                            gc_d[l] = '0;
                            wc_d[l] = '0;
                            bc_d[l] = '0;
                        end else if (wc_q[l] == 6'd63) begin
                            wc_d[l] = '0;
                            bc_d[l] = '0;
                        end else begin
                            wc_d[l] = wc_q[l] + 6'd1;
                            bc_d[l] = bc_q[l] + {3'b000, ~hv};
                        end
                    end
                    default: st_d[l] = UNLOCK;
                endcase
            end
        end
    end

    // Lock state and counters register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                st_q[l] <= UNLOCK;
                gc_q[l] <= '0;
                wc_q[l] <= '0;
                bc_q[l] <= '0;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                st_q[l] <= st_d[l];
                gc_q[l] <= gc_d[l];
                wc_q[l] <= wc_d[l];
                bc_q[l] <= bc_d[l];
            end
        end
    end

    // Lock is the registered state itself.
    always_comb begin
        lock = '0;
        for (int l = 0; l < LANES; l++) begin
            lock[l] = (st_q[l] == LOCKED);
        end
    end
`else
    assign lock = '1;
`endif

endmodule

// File: tb/tb_descrambler_mlane.sv
// tb_descrambler_mlane: random and directed stimulus against a bit-history reference model.
// Expected responses are queued at issue time and popped by an independent monitor.
// Covers reset, descrambling, bypass, header errors, counter saturation/clear and lock.
module tb_descrambler_mlane;
    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int ECW   = 16;
    localparam int BPB   = 64 / DW;
    localparam logic [LANES*2-1:0] HGOOD = {LANES{2'b01}};
`ifdef DESCR_LOCK_EN
    localparam logic [LANES-1:0] LOCK_RST = '0;
`else
    localparam logic [LANES-1:0] LOCK_RST = '1;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [LANES-1:0]    en = '0, sof = '0, byp = '0;
    logic [LANES*DW-1:0] data_i = '0;
    logic [LANES*2-1:0]  head_i = '0;
    logic                err_clr = 1'b0;
    logic [LANES*DW-1:0] data_o;
    logic [LANES*2-1:0]  head_o;
    logic [LANES-1:0]    sof_o, vld, hdr_err, lock;
    logic [ECW-1:0]      err_cnt;

    always #5 clk = ~clk;

    descrambler_mlane #(.LANES(LANES), .DW(DW), .ECW(ECW)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sof(sof), .data_i(data_i), .head_i(head_i),
        .byp(byp), .err_clr(err_clr), .data_o(data_o), .head_o(head_o), .sof_o(sof_o),
        .vld(vld), .hdr_err(hdr_err), .err_cnt(err_cnt), .lock(lock)
    );

    typedef struct packed {
        logic [LANES*DW-1:0] dat;
        logic [LANES*DW-1:0] pt;
        logic [LANES*2-1:0]  head;
        logic [LANES-1:0]    vld;
        logic [LANES-1:0]    sof;
        logic [LANES-1:0]    herr;
        logic [LANES-1:0]    lock;
        logic [LANES-1:0]    ptc;
        logic [ECW-1:0]      ecnt;
    } exp_t;

    exp_t expq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model: descrambler input history (out[n] = d[n]^d[n-39]^d[n-58], d[<0] = 1).
    bit                  dh [LANES][4096];
    int                  dn [LANES];
    // Reference scrambler: c[n] = p[n]^c[n-39]^c[n-58], arbitrary seed for c[<0].
    bit                  sh [LANES][4096];
    int                  sn [LANES];
    logic [57:0]         seedv [LANES];
    int                  bi [LANES];
    logic [LANES*DW-1:0] m_dat;
    logic [LANES*2-1:0]  m_head;
    logic [ECW-1:0]      m_err;
    bit                  m_lk [LANES];
    int                  m_gc [LANES];
    int                  m_bc [LANES];
    int                  m_wc [LANES];
    bit                  dir_ovr = 1'b0;
    logic [DW-1:0]       dir_val = '0;
    logic [63:0]         zblk = 64'h03FF_FF80_0000_0000;

    function automatic bit dget(int l, int k);
        if (k < 0) return 1'b1;
        return dh[l][k % 4096];
    endfunction

    function automatic bit sget(int l, int k);
        if (k < 0) return seedv[l][k + 58];
        return sh[l][k % 4096];
    endfunction

    function automatic logic [DW-1:0] scramble(int l, logic [DW-1:0] p);
        logic [DW-1:0] c;
        for (int i = 0; i < DW; i++) begin
            c[i] = p[i] ^ sget(l, sn[l] - 39) ^ sget(l, sn[l] - 58);
            sh[l][sn[l] % 4096] = c[i];
            sn[l]++;
        end
        return c;
    endfunction

    function automatic logic [LANES*DW-1:0] rnd_bus();
        logic [LANES*DW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*DW +: DW] = DW'({$urandom, $urandom});
        return v;
    endfunction

    function automatic logic [LANES*2-1:0] hdr_bus(bit bad);
        logic [LANES*2-1:0] h;
        for (int l = 0; l < LANES; l++) begin
            if (bad) h[2*l +: 2] = ($urandom_range(1) != 0) ? 2'b11 : 2'b00;
            else     h[2*l +: 2] = ($urandom_range(1) != 0) ? 2'b01 : 2'b10;
        end
        return h;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < LANES; l++) begin
            dn[l] = 0; m_lk[l] = 1'b0; m_gc[l] = 0; m_bc[l] = 0; m_wc[l] = 0;
        end
        m_dat = '0; m_head = '0; m_err = '0;
    endtask

`ifdef DESCR_LOCK_EN
    task automatic lock_model(int l, bit good);
        if (!m_lk[l]) begin
            if (good) begin
                m_gc[l]++;
                if (m_gc[l] == 64) begin m_lk[l] = 1'b1; m_bc[l] = 0; m_wc[l] = 0; end
            end else begin
                m_gc[l] = 0;
            end
        end else begin
            m_wc[l]++;
            if (!good) m_bc[l]++;
            if (m_bc[l] == 16) begin
                m_lk[l] = 1'b0; m_gc[l] = 0; m_bc[l] = 0; m_wc[l] = 0;
            end else if (m_wc[l] == 64) begin
                m_wc[l] = 0; m_bc[l] = 0;
            end
        end
    endtask
`endif

    task automatic chk(input string nm, input int lane, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s lane %0d: got %0h expected %0h at %0t", nm, lane, got, exp, $time);
        end
    endtask

    // Drive one cycle (called at posedge+1), model it, queue the expectation once it is captured.
    task automatic step(input logic [LANES-1:0] e, input logic [LANES-1:0] s, input logic [LANES-1:0] b,
                        input logic [LANES*DW-1:0] d, input logic [LANES*2-1:0] h, input logic clr,
                        input logic [LANES-1:0] ptc, input logic [LANES*DW-1:0] pt);
        exp_t       r;
        int         pop;
        int         sum;
        logic [1:0] hh;
        bit         x;
        en = e; sof = s; byp = b; data_i = d; head_i = h; err_clr = clr;
        pop = 0;
        r.herr = '0;
        for (int l = 0; l < LANES; l++) begin
            if (e[l]) begin
                for (int i = 0; i < DW; i++) begin
                    x = d[l*DW + i];
                    m_dat[l*DW + i] = b[l] ? x : (x ^ dget(l, dn[l] - 39) ^ dget(l, dn[l] - 58));
                    dh[l][dn[l] % 4096] = x;
                    dn[l]++;
                end
                if (s[l]) begin
                    hh = h[2*l +: 2];
                    m_head[2*l +: 2] = hh;
                    if (hh == 2'b00 || hh == 2'b11) begin r.herr[l] = 1'b1; pop++; end
`ifdef DESCR_LOCK_EN
                    lock_model(l, !(hh == 2'b00 || hh == 2'b11));
`endif
                end
            end
        end
        sum = int'(m_err) + pop;
        if (clr) m_err = '0;
        else if (sum > (2**ECW) - 1) m_err = '1;
        else m_err = ECW'(sum);
        r.dat = m_dat;
        if (dir_ovr) r.dat[DW-1:0] = dir_val;
        r.pt = pt; r.ptc = ptc; r.head = m_head;
        r.vld = e; r.sof = e & s; r.ecnt = m_err;
        for (int l = 0; l < LANES; l++) r.lock[l] = m_lk[l];
`ifndef DESCR_LOCK_EN
        r.lock = '1;
`endif
        @(posedge clk);
        expq.push_back(r);
        #1;
    endtask

    task automatic check_reset_outs();
        chk("rst_data_any", -1, 64'(|data_o), 64'd0);
        chk("rst_head", -1, 64'(head_o), 64'd0);
        chk("rst_sof", -1, 64'(sof_o), 64'd0);
        chk("rst_vld", -1, 64'(vld), 64'd0);
        chk("rst_hdr_err", -1, 64'(hdr_err), 64'd0);
        chk("rst_err_cnt", -1, 64'(err_cnt), 64'd0);
        chk("rst_lock", -1, 64'(lock), 64'(LOCK_RST));
    endtask

    // Asynchronous reset between edges; outputs must clear without waiting for a clock.
    task automatic mid_reset();
        @(negedge clk); #1;
        en = '0; sof = '0; byp = '0; err_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outs();
        @(negedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic dir_zero();
        for (int j = 0; j < 128 / DW; j++) begin
            dir_ovr = 1'b1;
            dir_val = (j * DW < 64) ? zblk[j*DW +: DW] : '0;
            step(4'b0001, (j % BPB == 0) ? 4'b0001 : 4'b0000, '0, '0, HGOOD, 1'b0, '0, '0);
        end
        dir_ovr = 1'b0;
        step('0, '0, '0, rnd_bus(), HGOOD, 1'b0, '0, '0);
    endtask

    task automatic hdr_beats(int n, bit bad);
        for (int k = 0; k < n; k++) step('1, '1, '0, rnd_bus(), hdr_bus(bad), 1'b0, '0, '0);
    endtask

    // Monitor: pop one expectation per captured cycle and compare everything the DUT presents.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                r = expq.pop_front();
                chk("vld", -1, 64'(vld), 64'(r.vld));
                chk("sof_o", -1, 64'(sof_o), 64'(r.sof));
                chk("hdr_err", -1, 64'(hdr_err), 64'(r.herr));
                chk("err_cnt", -1, 64'(err_cnt), 64'(r.ecnt));
                chk("lock", -1, 64'(lock), 64'(r.lock));
                for (int l = 0; l < LANES; l++) begin
                    chk("data_o", l, 64'(data_o[l*DW +: DW]), 64'(r.dat[l*DW +: DW]));
                    if (r.sof[l]) chk("head_o", l, 64'(head_o[2*l +: 2]), 64'(r.head[2*l +: 2]));
                    if (r.ptc[l]) chk("plaintext", l, 64'(data_o[l*DW +: DW]), 64'(r.pt[l*DW +: DW]));
                end
            end
        end
    end

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #2 check_reset_outs();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // All-zero input from the all-ones state: one 64-bit block of 0x03FFFF8000000000, then zeros.
        dir_zero();

        // Bad headers on lanes 0 and 2, then idle, then a sof without en, then clear racing errors.
        step('1, '1, '0, rnd_bus(), {2'b10, 2'b11, 2'b01, 2'b11}, 1'b0, '0, '0);
        step('0, '0, '0, rnd_bus(), HGOOD, 1'b0, '0, '0);
        step('0, '1, '0, rnd_bus(), '0, 1'b0, '0, '0);
        step('1, '1, '0, rnd_bus(), {2'b00, 2'b11, 2'b00, 2'b11}, 1'b1, '0, '0);
        step('1, '1, '0, rnd_bus(), {2'b01, 2'b01, 2'b11, 2'b10}, 1'b0, '0, '0);

        // Scrambled random blocks on all lanes, lane 1 bypassed for 10 beats, reset mid-stream.
        for (int l = 0; l < LANES; l++) begin
            sn[l] = 0; bi[l] = 0; seedv[l] = {26'($urandom), $urandom};
        end
        for (int c = 0; c < 600; c++) begin
            logic [LANES-1:0]    e, s, b, pc;
            logic [LANES*DW-1:0] d, pt;
            logic [LANES*2-1:0]  h;
            logic [DW-1:0]       p;
            if (c == 400) mid_reset();
            d = rnd_bus(); pt = '0; h = '0;
            for (int l = 0; l < LANES; l++) begin
                e[l] = ($urandom_range(3) != 0);
                b[l] = 1'b0;
                if (l == 1 && c >= 200 && c < 210) begin e[l] = 1'b1; b[l] = 1'b1; end
                s[l] = 1'($urandom_range(1));
                h[2*l +: 2] = 2'($urandom);
                pc[l] = 1'b0;
                if (e[l]) begin
                    p = DW'({$urandom, $urandom});
                    pc[l] = (dn[l] >= 58) && (sn[l] >= 58) && !b[l];
                    pt[l*DW +: DW] = p;
                    d[l*DW +: DW] = scramble(l, p);
                    s[l] = (bi[l] == 0);
                    bi[l] = (bi[l] + 1) % BPB;
                    if ($urandom_range(15) == 0) h[2*l +: 2] = ($urandom_range(1) != 0) ? 2'b11 : 2'b00;
                    else                         h[2*l +: 2] = ($urandom_range(1) != 0) ? 2'b01 : 2'b10;
                end
            end
            step(e, s, b, d, h, 1'b0, pc, pt);
        end

        // Fresh reset, all-ones state again.
        mid_reset();
        dir_zero();

        // Lock: a bad header restarts the good run; 64 good lock; 15 bad per window hold; 16 bad unlock.
        hdr_beats(30, 1'b0);
        hdr_beats(1, 1'b1);
        hdr_beats(64, 1'b0);
        for (int w = 0; w < 2; w++) begin
            hdr_beats(15, 1'b1);
            hdr_beats(49, 1'b0);
        end
        hdr_beats(16, 1'b1);
        hdr_beats(4, 1'b0);

        // Counter saturation: 65532 errors, +2 -> 0xFFFE, +2 -> 0xFFFF, +4 holds, clear wins, then counts again.
        mid_reset();
        hdr_beats(16383, 1'b1);
        step('1, '1, '0, rnd_bus(), {2'b01, 2'b11, 2'b10, 2'b00}, 1'b0, '0, '0);
        step('1, '1, '0, rnd_bus(), {2'b01, 2'b11, 2'b10, 2'b00}, 1'b0, '0, '0);
        hdr_beats(1, 1'b1);
        step('1, '1, '0, rnd_bus(), {2'b11, 2'b00, 2'b11, 2'b00}, 1'b1, '0, '0);
        step('1, '1, '0, rnd_bus(), {2'b01, 2'b01, 2'b01, 2'b11}, 1'b0, '0, '0);
        step('0, '0, '0, rnd_bus(), HGOOD, 1'b0, '0, '0);

        for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
        #1;
        chk("scoreboard_drain", -1, 64'(expq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
